// File: rtl/dsp_pkg.sv
// Shared constants for the DSP48A1 post-adder: OPMODE field encodings,
// OPMODE bit positions and datapath widths.
package dsp_pkg;

    localparam int P_W = 48;
    localparam int M_W = 36;

    // X mux select, OPMODE[1:0]
    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] X_P    = 2'b10;
    localparam logic [1:0] X_DAB  = 2'b11;

    // Z mux select, OPMODE[3:2]
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_PCIN = 2'b01;
    localparam logic [1:0] Z_P    = 2'b10;
    localparam logic [1:0] Z_C    = 2'b11;

    // OPMODE bit positions owned by the post-adder
    localparam int OPM_CIN = 5;
    localparam int OPM_SUB = 7;

endpackage

// File: rtl/dsp_post_adder_if.sv
// Operand, control and result bundle of the post-adder. The master side
// drives operands and enables; the slave side (the post-adder) returns
// the pre-PREG result and carry-out.
interface dsp_post_adder_if;

    logic [dsp_pkg::P_W-1:0] C;
    logic [dsp_pkg::M_W-1:0] M;
    logic [17:0]             D;
    logic [17:0]             A;
    logic [17:0]             B;
    logic [dsp_pkg::P_W-1:0] PCIN;
    logic [dsp_pkg::P_W-1:0] P_FB;
    logic [7:0]              OPMODE;
    logic                    CARRYIN;
    logic                    CEC;
    logic                    CEOPMODE;
    logic                    CECARRYIN;
    logic                    CECARRYOUT;
    logic [dsp_pkg::P_W-1:0] P_PRE;
    logic                    CARRYOUT;
    logic                    CARRYOUTF;

    modport master (
        output C, M, D, A, B, PCIN, P_FB, OPMODE, CARRYIN,
               CEC, CEOPMODE, CECARRYIN, CECARRYOUT,
        input  P_PRE, CARRYOUT, CARRYOUTF
    );

    modport slave (
        input  C, M, D, A, B, PCIN, P_FB, OPMODE, CARRYIN,
               CEC, CEOPMODE, CECARRYIN, CECARRYOUT,
        output P_PRE, CARRYOUT, CARRYOUTF
    );

endinterface

// File: rtl/dsp_reg_stage.sv
// Optional pipeline register with clock enable and asynchronous active-low
// clear. With REG = 0 the output is the input and the flop is left
// unloaded, so synthesis removes it.
module dsp_reg_stage #(
    parameter int WIDTH = 1,
    parameter int REG   = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q_mux
);

    logic [WIDTH-1:0] q;

    // Capture D on enabled edges; reset clears without waiting for a clock
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            q <= '0;
        end else if (CE) begin
            q <= D;
        end
    end

    assign Q_mux = (REG != 0) ? q : D;

endmodule

// File: rtl/dsp_post_adder.sv
// DSP48A1 post-adder/subtracter: selects X and Z per the effective OPMODE,
// forms Z + X + CIN or Z - (X + CIN) in 49 bits and presents the low 48
// bits to PREG together with the (optionally registered) carry-out.
module dsp_post_adder
    import dsp_pkg::*;
#(
    parameter int CREG        = 1,
    parameter int OPMODEREG   = 1,
    parameter int CARRYINREG  = 1,
    parameter int CARRYOUTREG = 1,
    parameter int CARRYINSEL  = 0
) (
    input logic             CLK,
    input logic             RSTN,
    dsp_post_adder_if.slave bus
);

    logic [P_W-1:0] c_eff;
    logic [7:0]     opm_eff;
    logic           cin_sel;
    logic           cin_eff;
    logic [P_W-1:0] x_mux;
    logic [P_W-1:0] z_mux;
    logic [P_W:0]   sum;
    logic           cyo_eff;
    logic           unused_bits;

    // Carry-in source is chosen from the raw OPMODE, ahead of its register
    assign cin_sel = (CARRYINSEL != 0) ? bus.OPMODE[OPM_CIN] : bus.CARRYIN;

    dsp_reg_stage #(.WIDTH(P_W), .REG(CREG)) u_c_reg (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .CE    (bus.CEC),
        .D     (bus.C),
        .Q_mux (c_eff)
    );

    dsp_reg_stage #(.WIDTH(8), .REG(OPMODEREG)) u_opmode_reg (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .CE    (bus.CEOPMODE),
        .D     (bus.OPMODE),
        .Q_mux (opm_eff)
    );

    dsp_reg_stage #(.WIDTH(1), .REG(CARRYINREG)) u_cin_reg (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .CE    (bus.CECARRYIN),
        .D     (cin_sel),
        .Q_mux (cin_eff)
    );

    // Operand muxes and 49-bit add/subtract; OPMODE = 0 yields zero operands
    always_comb begin
        x_mux = '0;
        z_mux = '0;
        case (opm_eff[1:0])
            X_ZERO:  x_mux = '0;
            X_M:     x_mux = {{(P_W-M_W){1'b0}}, bus.M};
            X_P:     x_mux = bus.P_FB;
            X_DAB:   x_mux = {bus.D[11:0], bus.A, bus.B};
            default: x_mux = '0;
        endcase
        case (opm_eff[3:2])
            Z_ZERO:  z_mux = '0;
            Z_PCIN:  z_mux = bus.PCIN;
            Z_P:     z_mux = bus.P_FB;
            Z_C:     z_mux = c_eff;
            default: z_mux = '0;
        endcase
        if (opm_eff[OPM_SUB]) begin
            sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin_eff});
        end else begin
            sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin_eff};
        end
    end

    dsp_reg_stage #(.WIDTH(1), .REG(CARRYOUTREG)) u_cyo_reg (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .CE    (bus.CECARRYOUT),
        .D     (sum[P_W]),
        .Q_mux (cyo_eff)
    );

    assign bus.P_PRE     = sum[P_W-1:0];
    assign bus.CARRYOUT  = cyo_eff;
    assign bus.CARRYOUTF = cyo_eff;

    // D[17:12] and the pre-adder OPMODE bits are not consumed here
    assign unused_bits = ^{bus.D[17:12], opm_eff[6], opm_eff[4]};

endmodule

// File: tb/tb_dsp_post_adder.sv
// Bench for dsp_post_adder: two instances (fully registered with CARRYIN
// port carry, and fully combinational with OPMODE[5] carry) share one
// stimulus stream and are compared against an arithmetic reference model
// through per-instance scoreboard queues.
module tb_dsp_post_adder;

    typedef struct {
        int creg;
        int opreg;
        int cinreg;
        int coreg;
        int cinsel;
    } cfg_t;

    typedef struct {
        logic [47:0] c_r;
        logic [7:0]  opm_r;
        logic        cin_r;
        logic        cyo_r;
    } st_t;

    typedef struct {
        string       nm;
        logic [49:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [47:0] c_v = '0;
    logic [35:0] m_v = '0;
    logic [17:0] d_v = '0;
    logic [17:0] a_v = '0;
    logic [17:0] b_v = '0;
    logic [47:0] pcin_v = '0;
    logic [47:0] pfb_v = '0;
    logic [7:0]  opm_v = '0;
    logic        cin_v = 1'b0;
    logic        cec = 1'b0;
    logic        ceop = 1'b0;
    logic        cecin = 1'b0;
    logic        cecyo = 1'b0;

    int errors = 0;
    int checks = 0;

    cfg_t cfg [2];
    st_t  st  [2];
    exp_t qa[$];
    exp_t qb[$];

    dsp_post_adder_if bus_a ();
    dsp_post_adder_if bus_b ();

    assign bus_a.C = c_v;          assign bus_b.C = c_v;
    assign bus_a.M = m_v;          assign bus_b.M = m_v;
    assign bus_a.D = d_v;          assign bus_b.D = d_v;
    assign bus_a.A = a_v;          assign bus_b.A = a_v;
    assign bus_a.B = b_v;          assign bus_b.B = b_v;
    assign bus_a.PCIN = pcin_v;    assign bus_b.PCIN = pcin_v;
    assign bus_a.P_FB = pfb_v;     assign bus_b.P_FB = pfb_v;
    assign bus_a.OPMODE = opm_v;   assign bus_b.OPMODE = opm_v;
    assign bus_a.CARRYIN = cin_v;  assign bus_b.CARRYIN = cin_v;
    assign bus_a.CEC = cec;        assign bus_b.CEC = cec;
    assign bus_a.CEOPMODE = ceop;  assign bus_b.CEOPMODE = ceop;
    assign bus_a.CECARRYIN = cecin;   assign bus_b.CECARRYIN = cecin;
    assign bus_a.CECARRYOUT = cecyo;  assign bus_b.CECARRYOUT = cecyo;

    dsp_post_adder #(
        .CREG(1), .OPMODEREG(1), .CARRYINREG(1), .CARRYOUTREG(1), .CARRYINSEL(0)
    ) dut_a (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus_a)
    );

    dsp_post_adder #(
        .CREG(0), .OPMODEREG(0), .CARRYINREG(0), .CARRYOUTREG(0), .CARRYINSEL(1)
    ) dut_b (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus_b)
    );

    always #5 clk = ~clk;

    // Reference: pick operands from the spec tables and do 49-bit arithmetic
    function automatic logic [48:0] model_sum(input cfg_t c, input st_t s);
        logic [47:0] ce;
        logic [7:0]  op;
        logic        ci;
        logic [47:0] xv;
        logic [47:0] zv;
        ce = (c.creg != 0) ? s.c_r : c_v;
        op = (c.opreg != 0) ? s.opm_r : opm_v;
        if (c.cinreg != 0) ci = s.cin_r;
        else ci = (c.cinsel != 0) ? opm_v[5] : cin_v;
        case (op[1:0])
            2'd0: xv = 48'd0;
            2'd1: xv = {12'd0, m_v};
            2'd2: xv = pfb_v;
            default: xv = {d_v[11:0], a_v, b_v};
        endcase
        case (op[3:2])
            2'd0: zv = 48'd0;
            2'd1: zv = pcin_v;
            2'd2: zv = pfb_v;
            default: zv = ce;
        endcase
        if (op[7]) return {1'b0, zv} - {1'b0, xv} - 49'(ci);
        return {1'b0, zv} + {1'b0, xv} + 49'(ci);
    endfunction

    function automatic logic [49:0] model_out(input int k);
        logic [48:0] s;
        logic        co;
        s  = model_sum(cfg[k], st[k]);
        co = (cfg[k].coreg != 0) ? st[k].cyo_r : s[48];
        return {co, co, s[47:0]};
    endfunction

    function automatic logic [49:0] dut_out(input int k);
        if (k == 0) return {bus_a.CARRYOUTF, bus_a.CARRYOUT, bus_a.P_PRE};
        return {bus_b.CARRYOUTF, bus_b.CARRYOUT, bus_b.P_PRE};
    endfunction

    task automatic chk(input string nm, input logic [49:0] act, input logic [49:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cyo_f=%b cyo=%b p=%h, expected cyo_f=%b cyo=%b p=%h",
                     nm, act[49], act[48], act[47:0], exp[49], exp[48], exp[47:0]);
        end
    endtask

    task automatic zero_state();
        for (int k = 0; k < 2; k++) st[k] = '{c_r: '0, opm_r: '0, cin_r: 1'b0, cyo_r: 1'b0};
    endtask

    // Immediate comparison of both instances with the current inputs
    task automatic check_now(input string nm);
        #1;
        chk({nm, "_a"}, dut_out(0), model_out(0));
        chk({nm, "_b"}, dut_out(1), model_out(1));
    endtask

    // Advance the model over one rising edge, queue the post-edge outputs,
    // then run the edge and return at the following falling edge
    task automatic cycle(input string nm);
        logic [48:0] s;
        logic        csel;
        exp_t        e;
        for (int k = 0; k < 2; k++) begin
            s    = model_sum(cfg[k], st[k]);
            csel = (cfg[k].cinsel != 0) ? opm_v[5] : cin_v;
            if (rstn) begin
                if (cec)   st[k].c_r   = c_v;
                if (ceop)  st[k].opm_r = opm_v;
                if (cecin) st[k].cin_r = csel;
                if (cecyo) st[k].cyo_r = s[48];
            end
            e.v = model_out(k);
            if (k == 0) begin e.nm = {nm, "_a"}; qa.push_back(e); end
            else        begin e.nm = {nm, "_b"}; qb.push_back(e); end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: after each rising edge compare every queued expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qa.size() > 0) begin e = qa.pop_front(); chk(e.nm, dut_out(0), e.v); end
        if (qb.size() > 0) begin e = qb.pop_front(); chk(e.nm, dut_out(1), e.v); end
    end

    task automatic all_ce(input logic v);
        cec = v; ceop = v; cecin = v; cecyo = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        cfg[0] = '{creg: 1, opreg: 1, cinreg: 1, coreg: 1, cinsel: 0};
        cfg[1] = '{creg: 0, opreg: 0, cinreg: 0, coreg: 0, cinsel: 1};
        zero_state();
        @(negedge clk);

        // Reset clears registers immediately, then release loads on edges
        opm_v = 8'h0F; c_v = 48'h1234; pfb_v = 48'h55;
        d_v = '0; a_v = '0; b_v = 18'h55; m_v = 36'h77; pcin_v = 48'h99;
        all_ce(1'b1);
        rstn = 1'b0;
        zero_state();
        check_now("reset_immediate");
        cycle("reset_hold");
        rstn = 1'b1;
        cycle("reset_release1");
        cycle("reset_release2");

        // Multiply-add with external carry
        opm_v = 8'h0D; m_v = 36'd100; c_v = 48'd5; cin_v = 1'b1;
        cycle("madd_edge1");
        cycle("madd_edge2");
        cycle("madd_edge3");

        // Subtract with borrow
        opm_v = 8'h8D; c_v = 48'd3; m_v = 36'd5; cin_v = 1'b0;
        cycle("sub_edge1");
        cycle("sub_edge2");
        cycle("sub_edge3");

        // Overflow wraps to zero with carry-out
        opm_v = 8'h0F; c_v = 48'hFFFF_FFFF_FFFF; d_v = '0; a_v = '0; b_v = 18'd1;
        cycle("wrap_edge1");
        cycle("wrap_edge2");
        cycle("wrap_edge3");

        // C clock-enable hold
        opm_v = 8'h0C; c_v = 48'd7; cec = 1'b1;
        cycle("ce_load");
        cec = 1'b0; c_v = 48'd9;
        for (int i = 0; i < 3; i++) cycle("ce_hold");
        cec = 1'b1;
        cycle("ce_release");

        // Combinational path with OPMODE[5] carry; CARRYIN port set opposite
        opm_v = 8'h2C; c_v = 48'd10; cin_v = 1'b0;
        check_now("bypass_same_cycle");
        cycle("bypass_edge1");
        cycle("bypass_edge2");

        // Randomized operands, enables and occasional mid-run reset
        for (int i = 0; i < 400; i++) begin
            c_v    = 48'({$urandom(), $urandom()});
            m_v    = 36'({$urandom(), $urandom()});
            d_v    = 18'($urandom());
            a_v    = 18'($urandom());
            b_v    = 18'($urandom());
            pcin_v = 48'({$urandom(), $urandom()});
            pfb_v  = 48'({$urandom(), $urandom()});
            opm_v  = 8'($urandom());
            cin_v  = 1'($urandom());
            cec    = ($urandom_range(0, 3) != 0);
            ceop   = ($urandom_range(0, 3) != 0);
            cecin  = ($urandom_range(0, 3) != 0);
            cecyo  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                rstn = 1'b0;
                zero_state();
                check_now("rand_reset");
            end else begin
                rstn = 1'b1;
            end
            cycle("random");
        end
        rstn = 1'b1;
        cycle("final");
        @(posedge clk);
        #2;

        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
